// File: rtl/bfu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bfu_pipe
// Purpose  : Pipelined radix-2 complex butterfly.
//            DIT : t = h*Tw; x = g + t; y = g - t
//            DIF : x = g + h; y = (g - h)*Tw
//            The twiddle product is rounded once (round-half-up). Optional /2
//            scaling is applied per sample, then each result saturates to W
//            bits. A valid/ready handshake stalls the whole pipeline.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_ready   - input handshake
//            g_*, h_*            - W-bit signed operands
//            Tw_*                - TW_W-bit signed Q1.(TW_W-1) twiddle
//            mode_dif, scale     - per-sample mode, sampled with the data
//            out_valid/out_ready - output handshake
//            x_*, y_*            - W-bit saturated results
//            ovf                 - this result clamped (qualified by out_valid)
//            ovf_sticky, ovf_clr - accumulated overflow flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module bfu_pipe #(
    parameter int W    = 16,
    parameter int TW_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    g_real,
    input  logic [W-1:0]    g_imag,
    input  logic [W-1:0]    h_real,
    input  logic [W-1:0]    h_imag,
    input  logic [TW_W-1:0] Tw_real,
    input  logic [TW_W-1:0] Tw_imag,
    input  logic            mode_dif,
    input  logic            scale,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    x_real,
    output logic [W-1:0]    x_imag,
    output logic [W-1:0]    y_real,
    output logic [W-1:0]    y_imag,
    output logic            ovf,
    output logic            ovf_sticky,
    input  logic            ovf_clr
);
    // Multiplicand is W+1 bits because DIF multiplies (g - h).
    localparam int c_AW = W + 1;
    localparam int c_MW = c_AW + TW_W;
    localparam int c_PW = c_MW + 1;
    localparam int c_SW = W + 2;

    localparam logic signed [c_PW-1:0] c_RND     = {{(c_PW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [c_SW:0]   c_ONE     = {{c_SW{1'b0}}, 1'b1};
    localparam logic signed [c_SW:0]   c_SAT_MAX = {{(c_SW+2-W){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [c_SW:0]   c_SAT_MIN = {{(c_SW+2-W){1'b1}}, {(W-1){1'b0}}};

    logic out_vld_q;
    logic en;

    // A result waiting at the output freezes every stage.
    assign en       = !(out_vld_q && !out_ready);
    assign in_ready = en;

    // ---------------- S1: operand select and four partial products ----------
    logic signed [c_AW-1:0] a_re, a_im, sum_re_d, sum_im_d;
    logic signed [c_MW-1:0] a_re_x, a_im_x, tw_re_x, tw_im_x;

    always_comb begin
        sum_re_d = $signed({g_real[W-1], g_real}) + $signed({h_real[W-1], h_real});
        sum_im_d = $signed({g_imag[W-1], g_imag}) + $signed({h_imag[W-1], h_imag});
        a_re     = $signed({h_real[W-1], h_real});
        a_im     = $signed({h_imag[W-1], h_imag});
        if (mode_dif) begin
            a_re = $signed({g_real[W-1], g_real}) - $signed({h_real[W-1], h_real});
            a_im = $signed({g_imag[W-1], g_imag}) - $signed({h_imag[W-1], h_imag});
        end
        a_re_x  = {{TW_W{a_re[c_AW-1]}}, a_re};
        a_im_x  = {{TW_W{a_im[c_AW-1]}}, a_im};
        tw_re_x = {{c_AW{Tw_real[TW_W-1]}}, Tw_real};
        tw_im_x = {{c_AW{Tw_imag[TW_W-1]}}, Tw_imag};
    end

    logic                   s1_vld_q, s1_dif_q, s1_scl_q;
    logic [W-1:0]           s1_g_re_q, s1_g_im_q;
    logic signed [c_AW-1:0] s1_sum_re_q, s1_sum_im_q;
    logic signed [c_MW-1:0] s1_rr_q, s1_ii_q, s1_ri_q, s1_ir_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= 1'b0;
            s1_dif_q    <= 1'b0;
            s1_scl_q    <= 1'b0;
            s1_g_re_q   <= '0;
            s1_g_im_q   <= '0;
            s1_sum_re_q <= '0;
            s1_sum_im_q <= '0;
            s1_rr_q     <= '0;
            s1_ii_q     <= '0;
            s1_ri_q     <= '0;
            s1_ir_q     <= '0;
        end else if (en) begin
            s1_vld_q    <= in_valid;
            s1_dif_q    <= mode_dif;
            s1_scl_q    <= scale;
            s1_g_re_q   <= g_real;
            s1_g_im_q   <= g_imag;
            s1_sum_re_q <= sum_re_d;
            s1_sum_im_q <= sum_im_d;
            s1_rr_q     <= a_re_x * tw_re_x;
            s1_ii_q     <= a_im_x * tw_im_x;
            s1_ri_q     <= a_re_x * tw_im_x;
            s1_ir_q     <= a_im_x * tw_re_x;
        end
    end

    // ---------------- S2: combine products, single round-half-up -----------
    logic signed [c_PW-1:0] p_re, p_im, p_re_sh, p_im_sh;
    logic signed [c_SW-1:0] t_re_d, t_im_d;
    logic                   unused_p_hi;

    always_comb begin
        p_re    = {s1_rr_q[c_MW-1], s1_rr_q} - {s1_ii_q[c_MW-1], s1_ii_q} + c_RND;
        p_im    = {s1_ri_q[c_MW-1], s1_ri_q} + {s1_ir_q[c_MW-1], s1_ir_q} + c_RND;
        p_re_sh = p_re >>> (TW_W-1);
        p_im_sh = p_im >>> (TW_W-1);
        // A rounded product of a W+1-bit operand and a unit-bounded twiddle
        // always fits in W+2 bits, so the upper bits are pure sign copies.
        t_re_d  = p_re_sh[c_SW-1:0];
        t_im_d  = p_im_sh[c_SW-1:0];
    end

    assign unused_p_hi = ^{p_re_sh[c_PW-1:c_SW], p_im_sh[c_PW-1:c_SW]};

    logic                   s2_vld_q, s2_dif_q, s2_scl_q;
    logic [W-1:0]           s2_g_re_q, s2_g_im_q;
    logic signed [c_AW-1:0] s2_sum_re_q, s2_sum_im_q;
    logic signed [c_SW-1:0] s2_t_re_q, s2_t_im_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld_q    <= 1'b0;
            s2_dif_q    <= 1'b0;
            s2_scl_q    <= 1'b0;
            s2_g_re_q   <= '0;
            s2_g_im_q   <= '0;
            s2_sum_re_q <= '0;
            s2_sum_im_q <= '0;
            s2_t_re_q   <= '0;
            s2_t_im_q   <= '0;
        end else if (en) begin
            s2_vld_q    <= s1_vld_q;
            s2_dif_q    <= s1_dif_q;
            s2_scl_q    <= s1_scl_q;
            s2_g_re_q   <= s1_g_re_q;
            s2_g_im_q   <= s1_g_im_q;
            s2_sum_re_q <= s1_sum_re_q;
            s2_sum_im_q <= s1_sum_im_q;
            s2_t_re_q   <= t_re_d;
            s2_t_im_q   <= t_im_d;
        end
    end

    // ---------------- S3: add/sub, optional /2, saturate -------------------
    // Returns {clamped, value}. Scaling happens before the clamp so that a
    // sum which only overflows by one bit is still representable.
    function automatic logic [W:0] scale_sat(input logic signed [c_SW-1:0] r,
                                             input logic                   sc);
        logic signed [c_SW:0] v;
        v = {r[c_SW-1], r};
        if (sc) begin
            v = (v + c_ONE) >>> 1;
        end
        if (v > c_SAT_MAX) begin
            scale_sat = {1'b1, c_SAT_MAX[W-1:0]};
        end else if (v < c_SAT_MIN) begin
            scale_sat = {1'b1, c_SAT_MIN[W-1:0]};
        end else begin
            scale_sat = {1'b0, v[W-1:0]};
        end
    endfunction

    logic signed [c_SW-1:0] g_re_x, g_im_x, res_xre, res_xim, res_yre, res_yim;
    logic [W:0]             sat_xre, sat_xim, sat_yre, sat_yim;
    logic                   ovf_d;

    always_comb begin
        g_re_x  = {{2{s2_g_re_q[W-1]}}, s2_g_re_q};
        g_im_x  = {{2{s2_g_im_q[W-1]}}, s2_g_im_q};
        res_xre = g_re_x + s2_t_re_q;
        res_xim = g_im_x + s2_t_im_q;
        res_yre = g_re_x - s2_t_re_q;
        res_yim = g_im_x - s2_t_im_q;
        if (s2_dif_q) begin
            res_xre = {s2_sum_re_q[c_AW-1], s2_sum_re_q};
            res_xim = {s2_sum_im_q[c_AW-1], s2_sum_im_q};
            res_yre = s2_t_re_q;
            res_yim = s2_t_im_q;
        end
        sat_xre = scale_sat(res_xre, s2_scl_q);
        sat_xim = scale_sat(res_xim, s2_scl_q);
        sat_yre = scale_sat(res_yre, s2_scl_q);
        sat_yim = scale_sat(res_yim, s2_scl_q);
        ovf_d   = s2_vld_q & (sat_xre[W] | sat_xim[W] | sat_yre[W] | sat_yim[W]);
    end

    logic [W-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
    logic         ovf_q, sticky_q, sticky_d;

    // Set wins over a same-cycle clear.
    assign sticky_d = (out_vld_q & out_ready & ovf_q) | (sticky_q & ~ovf_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld_q <= 1'b0;
            x_re_q    <= '0;
            x_im_q    <= '0;
            y_re_q    <= '0;
            y_im_q    <= '0;
            ovf_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (en) begin
                out_vld_q <= s2_vld_q;
                x_re_q    <= sat_xre[W-1:0];
                x_im_q    <= sat_xim[W-1:0];
                y_re_q    <= sat_yre[W-1:0];
                y_im_q    <= sat_yim[W-1:0];
                ovf_q     <= ovf_d;
            end
        end
    end

    assign out_valid  = out_vld_q;
    assign x_real     = x_re_q;
    assign x_imag     = x_im_q;
    assign y_real     = y_re_q;
    assign y_imag     = y_im_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_bfu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfu_pipe
// Purpose  : Directed self-checking bench for bfu_pipe (W = TW_W = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfu_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] g_real = '0, g_imag = '0, h_real = '0, h_imag = '0;
    logic [15:0] Tw_real = '0, Tw_imag = '0;
    logic        mode_dif = 1'b0, scale = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] x_real, x_imag, y_real, y_imag;
    logic        ovf, ovf_sticky;
    logic        ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bfu_pipe #(.W(16), .TW_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .g_real(g_real), .g_imag(g_imag), .h_real(h_real), .h_imag(h_imag),
        .Tw_real(Tw_real), .Tw_imag(Tw_imag),
        .mode_dif(mode_dif), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_real(x_real), .x_imag(x_imag), .y_real(y_real), .y_imag(y_imag),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] gr, gi, hr, hi, tr, ti,
                         input logic dif, sc);
        g_real = gr; g_imag = gi; h_real = hr; h_imag = hi;
        Tw_real = tr; Tw_imag = ti; mode_dif = dif; scale = sc;
        in_valid = 1'b1;
    endtask

    // One sample in, then wait until its result sits at the output.
    task automatic run_one(input logic [15:0] gr, gi, hr, hi, tr, ti,
                           input logic dif, sc);
        drive(gr, gi, hr, hi, tr, ti, dif, sc);
        step;
        in_valid = 1'b0;
        step;
        step;
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        #12;
        total++;
        if ({out_valid, x_real, x_imag, y_real, y_imag, ovf, ovf_sticky} !== 67'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b x=%h,%h y=%h,%h ovf=%b st=%b want all zero",
                     out_valid, x_real, x_imag, y_real, y_imag, ovf, ovf_sticky);
        end
        step;
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_dit_basic;
        drive(16'h27c8, 16'h0, 16'h3ba6, 16'h0, 16'h7fff, 16'h0, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_cycle1: out_valid got %b want 0", out_valid);
        end
        step;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_cycle2: out_valid got %b want 0", out_valid);
        end
        step;
        total++;
        if ({out_valid, x_real, x_imag, y_real, y_imag, ovf} !== {1'b1, 16'h636e, 16'h0, 16'hec22, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL dit_real: got v=%b x=%h,%h y=%h,%h ovf=%b want v=1 x=636e,0000 y=ec22,0000 ovf=0",
                     out_valid, x_real, x_imag, y_real, y_imag, ovf);
        end
        run_one(16'h0, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h7fff, 1'b0, 1'b0);
        total++;
        if ({out_valid, x_real, x_imag, y_real, y_imag, ovf} !== {1'b1, 16'h0, 16'h4000, 16'h0, 16'hc000, 1'b0}) begin
            bad++;
            $display("FAIL dit_imag_tw: got v=%b x=%h,%h y=%h,%h ovf=%b want v=1 x=0000,4000 y=0000,c000 ovf=0",
                     out_valid, x_real, x_imag, y_real, y_imag, ovf);
        end
        step;
    endtask

    task automatic test_saturation;
        run_one(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7fff, 16'h0, 1'b0, 1'b0);
        total++;
        if ({x_real, x_imag, y_real, y_imag, ovf} !== {16'h7fff, 16'h0, 16'h0001, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL sat_noscale: got x=%h,%h y=%h,%h ovf=%b want x=7fff,0000 y=0001,0000 ovf=1",
                     x_real, x_imag, y_real, y_imag, ovf);
        end
        step;
        total++;
        if ({out_valid, ovf_sticky} !== 2'b01) begin
            bad++;
            $display("FAIL sticky_set: got v=%b st=%b want v=0 st=1", out_valid, ovf_sticky);
        end
        run_one(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7fff, 16'h0, 1'b0, 1'b1);
        total++;
        if ({x_real, x_imag, y_real, y_imag, ovf, ovf_sticky} !== {16'h7000, 16'h0, 16'h0001, 16'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sat_scaled: got x=%h,%h y=%h,%h ovf=%b st=%b want x=7000,0000 y=0001,0000 ovf=0 st=1",
                     x_real, x_imag, y_real, y_imag, ovf, ovf_sticky);
        end
        // h = -1, Tw = -1: product is exactly +1.0, not truncated before the clamp.
        run_one(16'h0, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0);
        total++;
        if ({x_real, x_imag, y_real, y_imag, ovf} !== {16'h7fff, 16'h0, 16'h8000, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL neg1_sq: got x=%h,%h y=%h,%h ovf=%b want x=7fff,0000 y=8000,0000 ovf=1",
                     x_real, x_imag, y_real, y_imag, ovf);
        end
        run_one(16'h0, 16'h0, 16'h8000, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b1);
        total++;
        if ({x_real, x_imag, y_real, y_imag, ovf} !== {16'h4000, 16'h0, 16'hc000, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL neg1_sq_scaled: got x=%h,%h y=%h,%h ovf=%b want x=4000,0000 y=c000,0000 ovf=0",
                     x_real, x_imag, y_real, y_imag, ovf);
        end
        step;
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        total++;
        if (ovf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clear: got %b want 0", ovf_sticky);
        end
    endtask

    task automatic test_dif;
        run_one(16'h1000, 16'h0, 16'h0800, 16'h0, 16'h8000, 16'h0, 1'b1, 1'b0);
        total++;
        if ({out_valid, x_real, x_imag, y_real, y_imag, ovf} !== {1'b1, 16'h1800, 16'h0, 16'hf800, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL dif_basic: got v=%b x=%h,%h y=%h,%h ovf=%b want v=1 x=1800,0000 y=f800,0000 ovf=0",
                     out_valid, x_real, x_imag, y_real, y_imag, ovf);
        end
        step;
    endtask

    task automatic test_back_to_back;
        int          sent = 0;
        int          recv = 0;
        logic        have_held = 1'b0;
        logic [63:0] held = '0;
        logic [15:0] ex_xr, ex_yr, ex_im;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 8);
            if (sent < 6) begin
                // Tw = -1 gives t = -h exactly, so x = g - h and y = g + h.
                drive(16'((sent + 1) * 256), 16'(sent + 1), 16'h0010, 16'h0,
                      16'h8000, 16'h0, 1'b0, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && out_valid) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready: cyc=%0d got %b want 0", cyc, in_ready);
                end
                if (!have_held) begin
                    held      = {x_real, x_imag, y_real, y_imag};
                    have_held = 1'b1;
                end else begin
                    total++;
                    if ({x_real, x_imag, y_real, y_imag} !== held) begin
                        bad++;
                        $display("FAIL stall_stable: cyc=%0d got %h want %h", cyc,
                                 {x_real, x_imag, y_real, y_imag}, held);
                    end
                end
            end
            if (out_valid && out_ready) begin
                ex_xr = 16'((recv + 1) * 256 - 16);
                ex_yr = 16'((recv + 1) * 256 + 16);
                ex_im = 16'(recv + 1);
                total++;
                if ({x_real, x_imag, y_real, y_imag} !== {ex_xr, ex_im, ex_yr, ex_im}) begin
                    bad++;
                    $display("FAIL stream_order: idx=%0d got x=%h,%h y=%h,%h want x=%h,%h y=%h,%h",
                             recv, x_real, x_imag, y_real, y_imag, ex_xr, ex_im, ex_yr, ex_im);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (recv !== 6 || have_held !== 1'b1) begin
            bad++;
            $display("FAIL stream_count: got recv=%0d held=%b want recv=6 held=1", recv, have_held);
        end
        step;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_dup: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7fff, 16'h0, 1'b0, 1'b0);
            step;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        total++;
        if ({out_valid, x_real, y_real, ovf, ovf_sticky} !== 35'd0) begin
            bad++;
            $display("FAIL reset_async: got v=%b x=%h y=%h ovf=%b st=%b want all zero",
                     out_valid, x_real, y_real, ovf, ovf_sticky);
        end
        step;
        step;
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            step;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stale_result: cycle=%0d out_valid got %b want 0", k, out_valid);
            end
        end
        run_one(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7fff, 16'h0, 1'b0, 1'b0);
        total++;
        if ({out_valid, ovf, ovf_sticky} !== 3'b110) begin
            bad++;
            $display("FAIL pre_clr_state: got v=%b ovf=%b st=%b want v=1 ovf=1 st=0",
                     out_valid, ovf, ovf_sticky);
        end
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        total++;
        if (ovf_sticky !== 1'b1) begin
            bad++;
            $display("FAIL set_beats_clear: got %b want 1", ovf_sticky);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_dit_basic;
        test_saturation;
        test_dif;
        test_back_to_back;
        test_reset_inflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
